// File: rtl/complex_accum_pkg.sv
// rtl/complex_accum_pkg.sv - shared defaults, state encoding and guard-width helper for complex_accum
package complex_accum_pkg;

    localparam int QI_DEFAULT = 4;
    localparam int QF_DEFAULT = 4;
    localparam int N_DEFAULT  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    // Extra integer bits needed so a sum of n samples can never wrap.
    function automatic int guard_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/complex_accum_sat.sv
// rtl/complex_accum_sat.sv - per-component output range stage; clamps when COMPLEX_ACCUM_SAT_EN is defined, wraps otherwise
module complex_accum_sat #(
    parameter int W_ACC = 10,
    parameter int W_OUT = 8
) (
    input  logic signed [W_ACC-1:0] acc,
    output logic signed [W_OUT-1:0] value,
    output logic                    ovf
);

`ifdef COMPLEX_ACCUM_SAT_EN
    logic [W_ACC-W_OUT:0] hi;
    logic                 in_range;

    // The value fits only when every bit above the output sign bit copies it.
    assign hi       = acc[W_ACC-1:W_OUT-1];
    assign in_range = (&hi) | ~(|hi);
    assign ovf      = ~in_range;

    always_comb begin
        value = acc[W_OUT-1:0];
        if (!in_range) begin
            value = acc[W_ACC-1] ? {1'b1, {(W_OUT-1){1'b0}}}
                                 : {1'b0, {(W_OUT-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^acc[W_ACC-1:W_OUT];
    assign value     = acc[W_OUT-1:0];
    assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/complex_accum.sv
// rtl/complex_accum.sv - block accumulator for complex products; output range mode set by COMPLEX_ACCUM_SAT_EN
module complex_accum
    import complex_accum_pkg::*;
#(
    parameter int QI = QI_DEFAULT,
    parameter int QF = QF_DEFAULT,
    parameter int N  = N_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [QI+QF-1:0]    in_Re,
    input  logic signed [QI+QF-1:0]    in_Im,
    input  logic                       in_ovf_mult,
    input  logic                       in_ovf_add_sub,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [QI+QF-1:0]    out_Re,
    output logic signed [QI+QF-1:0]    out_Im,
    output logic [$clog2(N+1)-1:0]     out_count,
    output logic                       out_ovf
);

    localparam int W  = QI + QF;
    localparam int G  = guard_bits(N);
    localparam int WA = W + G;
    localparam int CW = $clog2(N + 1);

    state_t               state;
    logic signed [WA-1:0] acc_re;
    logic signed [WA-1:0] acc_im;
    logic [CW-1:0]        count;
    logic                 sticky;

    logic                 accept;
    logic                 release_hold;
    logic                 close;
    logic [CW-1:0]        count_next;
    logic signed [WA-1:0] in_re_x;
    logic signed [WA-1:0] in_im_x;

    logic signed [W-1:0]  sat_re;
    logic signed [W-1:0]  sat_im;
    logic                 sat_ovf_re;
    logic                 sat_ovf_im;

    assign in_ready     = (state != ST_HOLD);
    assign out_valid    = (state == ST_HOLD);
    assign accept       = in_valid && in_ready;
    assign release_hold = out_valid && out_ready;

    assign in_re_x = {{G{in_Re[W-1]}}, in_Re};
    assign in_im_x = {{G{in_Im[W-1]}}, in_Im};

    assign count_next = (state == ST_IDLE) ? CW'(1) : count + CW'(1);
    assign close      = in_last || (count_next == CW'(N));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            acc_re <= '0;
            acc_im <= '0;
            count  <= '0;
            sticky <= 1'b0;
        end else if (accept) begin
            // The first beat of a block loads so no separate clear cycle is needed.
            if (state == ST_IDLE) begin
                acc_re <= in_re_x;
                acc_im <= in_im_x;
                sticky <= in_ovf_mult | in_ovf_add_sub;
            end else begin
                acc_re <= acc_re + in_re_x;
                acc_im <= acc_im + in_im_x;
                sticky <= sticky | in_ovf_mult | in_ovf_add_sub;
            end
            count <= count_next;
            state <= close ? ST_HOLD : ST_ACCUM;
        end else if (release_hold) begin
            state  <= ST_IDLE;
            acc_re <= '0;
            acc_im <= '0;
            count  <= '0;
            sticky <= 1'b0;
        end
    end

    complex_accum_sat #(
        .W_ACC (WA),
        .W_OUT (W)
    ) u_sat_re (
        .acc   (acc_re),
        .value (sat_re),
        .ovf   (sat_ovf_re)
    );

    complex_accum_sat #(
        .W_ACC (WA),
        .W_OUT (W)
    ) u_sat_im (
        .acc   (acc_im),
        .value (sat_im),
        .ovf   (sat_ovf_im)
    );

    assign out_Re    = out_valid ? sat_re : '0;
    assign out_Im    = out_valid ? sat_im : '0;
    assign out_count = out_valid ? count  : '0;
    assign out_ovf   = out_valid ? (sticky | sat_ovf_re | sat_ovf_im) : 1'b0;

endmodule

// File: tb/tb_complex_accum.sv
// tb/tb_complex_accum.sv - directed table-driven bench for complex_accum (N=4, Q4.4)
module tb_complex_accum;

    localparam int QI = 4;
    localparam int QF = 4;
    localparam int N  = 4;
    localparam int W  = QI + QF;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_re;
    logic [W-1:0]  in_im;
    logic          in_ovf_mult;
    logic          in_ovf_add_sub;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_re;
    logic [W-1:0]  out_im;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    int total;
    int bad;

    complex_accum #(
        .QI (QI),
        .QF (QF),
        .N  (N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_Re          (in_re),
        .in_Im          (in_im),
        .in_ovf_mult    (in_ovf_mult),
        .in_ovf_add_sub (in_ovf_add_sub),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_Re         (out_re),
        .out_Im         (out_im),
        .out_count      (out_count),
        .out_ovf        (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][7:0] re;
        logic [3:0][7:0] im;
        logic [3:0]      fm;
        logic [3:0]      fa;
        logic            last;
        logic [7:0]      exp_re;
        logic [7:0]      exp_im;
        int              exp_cnt;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        in_re          = '0;
        in_im          = '0;
        in_ovf_mult    = 1'b0;
        in_ovf_add_sub = 1'b0;
        in_last        = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] re, input logic [7:0] im,
                             input logic fm, input logic fa, input logic last);
        in_valid       = 1'b1;
        in_re          = re;
        in_im          = im;
        in_ovf_mult    = fm;
        in_ovf_add_sub = fa;
        in_last        = last;
        chk("in_ready_beat", int'(in_ready), 1);
        tick();
        idle_inputs();
    endtask

    task automatic check_result(input string tag, input logic [7:0] re, input logic [7:0] im,
                                input int cnt, input logic ovf);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_in_ready"},  int'(in_ready), 0);
        chk({tag, "_re"},        int'(out_re), int'(re));
        chk({tag, "_im"},        int'(out_im), int'(im));
        chk({tag, "_count"},     int'(out_count), cnt);
        chk({tag, "_ovf"},       int'(out_ovf), int'(ovf));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, int'(out_valid), 0);
        chk({tag, "_idle_ready"}, int'(in_ready), 1);
        chk({tag, "_idle_re"},    int'(out_re), 0);
        chk({tag, "_idle_count"}, int'(out_count), 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();

        // 1.0+0.5i four times, closes on count
        vecs[0] = '{4, {8'h10, 8'h10, 8'h10, 8'h10}, {8'h08, 8'h08, 8'h08, 8'h08},
                    4'b0000, 4'b0000, 1'b0, 8'h40, 8'h20, 4, 1'b0};
        // early close with in_last on second beat, negative imaginary
        vecs[1] = '{2, {8'h00, 8'h00, 8'h10, 8'h34}, {8'h00, 8'h00, 8'hF0, 8'h20},
                    4'b0000, 4'b0000, 1'b1, 8'h44, 8'h10, 2, 1'b0};
`ifdef COMPLEX_ACCUM_SAT_EN
        vecs[2] = '{4, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, {8'h80, 8'h80, 8'h80, 8'h80},
                    4'b0000, 4'b0000, 1'b0, 8'h7F, 8'h80, 4, 1'b1};
`else
        vecs[2] = '{4, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, {8'h80, 8'h80, 8'h80, 8'h80},
                    4'b0000, 4'b0000, 1'b0, 8'hFC, 8'h00, 4, 1'b0};
`endif
        // multiplier flag on beat 2 makes the block sticky
        vecs[3] = '{4, {8'h01, 8'h01, 8'h01, 8'h01}, {8'h02, 8'h02, 8'h02, 8'h02},
                    4'b0000, 4'b0000, 1'b0, 8'h04, 8'h08, 4, 1'b1};
        vecs[3].fm = 4'b0010;
        // the following clean block must not inherit the flag
        vecs[4] = '{4, {8'h01, 8'h01, 8'h01, 8'h01}, {8'h02, 8'h02, 8'h02, 8'h02},
                    4'b0000, 4'b0000, 1'b0, 8'h04, 8'h08, 4, 1'b0};
        // single-beat block with add/sub flag
        vecs[5] = '{1, {8'h00, 8'h00, 8'h00, 8'hF8}, {8'h00, 8'h00, 8'h00, 8'h05},
                    4'b0000, 4'b0001, 1'b1, 8'hF8, 8'h05, 1, 1'b1};
        // in_last coincides with the N-th beat
        vecs[6] = '{4, {8'h01, 8'h01, 8'h01, 8'h01}, {8'h01, 8'h01, 8'h01, 8'h01},
                    4'b0000, 4'b0000, 1'b1, 8'h04, 8'h04, 4, 1'b0};
        // three negative beats
        vecs[7] = '{3, {8'h00, 8'hF0, 8'hF0, 8'hF0}, {8'h00, 8'h10, 8'h10, 8'h10},
                    4'b0000, 4'b0000, 1'b1, 8'hD0, 8'h30, 3, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_re",    int'(out_re), 0);
        chk("rst_out_im",    int'(out_im), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_ovf",   int'(out_ovf), 0);

        for (int v = 0; v < 8; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                chk($sformatf("v%0d_pre_valid", v), int'(out_valid), 0);
                send_beat(vecs[v].re[b], vecs[v].im[b], vecs[v].fm[b], vecs[v].fa[b],
                          vecs[v].last && (b == vecs[v].n - 1));
            end
            check_result($sformatf("v%0d", v), vecs[v].exp_re, vecs[v].exp_im,
                         vecs[v].exp_cnt, vecs[v].exp_ovf);
            release_result($sformatf("v%0d", v));
        end

        // Held result must survive back-pressure and ignore incoming beats.
        send_beat(8'h34, 8'h20, 1'b0, 1'b0, 1'b0);
        send_beat(8'h10, 8'hF0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_re    = 8'h55;
        in_im    = 8'h66;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_result($sformatf("hold%0d", c), 8'h44, 8'h10, 2, 1'b0);
            tick();
        end
        idle_inputs();
        release_result("hold");
        send_beat(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        check_result("after_hold", 8'h01, 8'h01, 1, 1'b0);
        release_result("after_hold");

        // Reset mid-block discards the partial sum.
        send_beat(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        send_beat(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("midrst_no_valid", int'(out_valid), 0);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            send_beat(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        end
        check_result("post_rst", 8'h40, 8'h40, 4, 1'b0);

        // Reset while holding drops the result.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst_valid", int'(out_valid), 0);
        chk("hold_rst_ready", int'(in_ready), 1);
        chk("hold_rst_re",    int'(out_re), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/complex_accum.md
COMPLEX_ACCUM -- requirements
Module: complex_accum

Interface
REQ-001 Parameter QI, default 4, integer bits of the signed Q(QI).(QF) sample format.
REQ-002 Parameter QF, default 4, fractional bits.
REQ-003 Parameter N, default 8, maximum products per accumulation block (N >= 2).
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, product beat valid.
REQ-007 Port in_ready, output, 1, block accepts a beat this cycle.
REQ-008 Port in_Re, in_Im, input, QI+QF each, signed complex product from the fixed-point complex multiplier.
REQ-009 Port in_ovf_mult, in_ovf_add_sub, input, 1 each, multiplier overflow flags accompanying the beat.
REQ-010 Port in_last, input, 1, beat closes the block early.
REQ-011 Port out_valid, input-side pair out_ready, output/input, 1 each, result handshake.
REQ-012 Port out_Re, out_Im, output, QI+QF each, signed accumulated sum in Q(QI).(QF).
REQ-013 Port out_count, output, clog2(N+1), number of beats summed.
REQ-014 Port out_ovf, output, 1, sticky overflow for the block.

Function
REQ-015 Beat accepted when in_valid && in_ready; no other cycle changes accumulator.
REQ-016 FSM states: IDLE (acc empty), ACCUM (>=1 beat held), HOLD (result presented).
REQ-017 IDLE -> ACCUM on accepted beat without close; IDLE/ACCUM -> HOLD on accepted beat with in_last=1 or count reaching N.
REQ-018 HOLD -> IDLE when out_valid && out_ready; accumulator, count, sticky flag cleared same edge.
REQ-019 in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-020 Accumulators signed, width QI+QF+clog2(N); first beat of block loads, later beats add, no wrap internally.
REQ-021 Latency: out_valid asserts the cycle after the closing beat is accepted.
REQ-022 out_Re/out_Im/out_count/out_ovf stable throughout HOLD regardless of in_* activity.
REQ-023 out_ovf = OR of all in_ovf_mult, in_ovf_add_sub of accepted beats, OR output range overflow per REQ-030.
REQ-024 in_last on the N-th beat closes once; count never exceeds N.
REQ-025 out_Re/out_Im/out_count/out_ovf drive zero outside HOLD.

Reset
REQ-026 rst has priority over all handshakes; next state IDLE.
REQ-027 After reset: in_ready=1, out_valid=0, out_Re=out_Im=0, out_count=0, out_ovf=0, accumulators zero.
REQ-028 Reset mid-block or in HOLD discards partial/held result; no result emitted.

Configuration
REQ-029 Macro COMPLEX_ACCUM_SAT_EN selects output range handling.
REQ-030 Defined: accumulator clamped to [-2^(QI-1), 2^(QI-1)-2^-QF] on output, out_ovf set when clamping occurs.
REQ-031 Undefined: output is the low QI+QF bits of the accumulator (two's-complement wrap), out_ovf reflects input flags only.

Structure
REQ-032 Shared package holds QI/QF defaults, state encoding typedef, and the accumulator guard-width constant function.
REQ-033 One sub-module complex_accum_sat (range check + clamp/truncate per component), instantiated twice for Re and Im.

Verification
REQ-034 N=4, four beats in=(0x10,0x08) (1.0+0.5i), no last -> one cycle later out=(0x40,0x20), count=4, ovf=0.
REQ-035 Two beats (0x34,0x20) then (0x10,0xF0) with in_last on second -> out=(0x44,0x10), count=2, in_ready low in HOLD.
REQ-036 N=4, four beats (0x7F,0x80) -> SAT_EN: out=(0x7F,0x80), ovf=1; no macro: out=(0xFC,0x00), ovf=0.
REQ-037 Result pending, out_ready low 3 cycles with in_valid high -> out stable, no beat accepted, in_ready=0; IDLE after out_ready.
REQ-038 in_ovf_mult=1 on beat 2 of block A -> A ovf=1; following clean block B -> ovf=0.
REQ-039 rst asserted after 2 of 4 beats -> out_valid never rises; fresh 4-beat block of 0x10 gives out_Re=0x40.
